// File: rtl/spikehard_dma_pkg.sv
// Shared constants for the 64-bit DMA memory responder: the beat size code
// and the read/write engine state encodings.
package spikehard_dma_pkg;

   localparam logic [2:0] DMA_SIZE_64 = 3'b011;

   localparam logic [0:0] R_IDLE  = 1'b0;
   localparam logic [0:0] R_BURST = 1'b1;

   localparam logic [0:0] W_IDLE  = 1'b0;
   localparam logic [0:0] W_BURST = 1'b1;

endpackage

// File: rtl/dma64_mem_ram.sv
// Beat-wide storage: one write port, one enabled synchronous read port for the
// DMA read engine and one free-running synchronous read port for the host.
module dma64_mem_ram #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              a_en,
   input  logic [ADDR_W-1:0] a_addr,
   output logic [DATA_W-1:0] a_rdata,
   input  logic [ADDR_W-1:0] b_addr,
   output logic [DATA_W-1:0] b_rdata
);

   logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

   // NOTE: the array is deliberately left out of reset so it maps onto block
   // RAM and keeps its contents across a mid-burst reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      // Read-before-write: a same-cycle write to the read address returns old data.
      if (a_en) a_rdata <= mem[a_addr];
      b_rdata <= mem[b_addr];
   end

endmodule

// File: rtl/dma64_mem_responder.sv
// Memory-backed DMA responder: independent read and write burst engines over a
// shared RAM, plus a host backdoor port for preload and checking.
module dma64_mem_responder
   import spikehard_dma_pkg::*;
#(
   parameter int DMA_BUS_WIDTH = 64,
   parameter int MEM_ADDR_W    = 12
) (
   input  logic                     clk,
   input  logic                     rst,

   input  logic                     dma_read_ctrl_valid,
   output logic                     dma_read_ctrl_ready,
   input  logic [31:0]              dma_read_ctrl_data_index,
   input  logic [31:0]              dma_read_ctrl_data_length,
   input  logic [2:0]               dma_read_ctrl_data_size,

   output logic                     dma_read_chnl_valid,
   output logic [DMA_BUS_WIDTH-1:0] dma_read_chnl_data,
   input  logic                     dma_read_chnl_ready,

   input  logic                     dma_write_ctrl_valid,
   output logic                     dma_write_ctrl_ready,
   input  logic [31:0]              dma_write_ctrl_data_index,
   input  logic [31:0]              dma_write_ctrl_data_length,
   input  logic [2:0]               dma_write_ctrl_data_size,

   input  logic                     dma_write_chnl_valid,
   input  logic [DMA_BUS_WIDTH-1:0] dma_write_chnl_data,
   output logic                     dma_write_chnl_ready,

   input  logic                     host_we,
   input  logic [MEM_ADDR_W-1:0]    host_addr,
   input  logic [DMA_BUS_WIDTH-1:0] host_wdata,
   output logic [DMA_BUS_WIDTH-1:0] host_rdata,

   output logic [31:0]              rd_beat_count,
   output logic [31:0]              wr_beat_count,
   output logic                     size_err
);

   logic [0:0]            rd_state, wr_state;
   logic [MEM_ADDR_W-1:0] rd_addr, wr_addr;
   logic [31:0]           rd_remaining, wr_remaining;

   logic rd_ctrl_fire, rd_beat_fire, wr_ctrl_fire, wr_beat_fire;
   logic rd_fetch_en;
   logic [MEM_ADDR_W-1:0] rd_fetch_addr;

   logic                     ram_we;
   logic [MEM_ADDR_W-1:0]    ram_waddr;
   logic [DMA_BUS_WIDTH-1:0] ram_wdata;

   logic unused_index_hi;
   assign unused_index_hi = ^{dma_read_ctrl_data_index[31:MEM_ADDR_W],
                              dma_write_ctrl_data_index[31:MEM_ADDR_W]};

   assign dma_read_ctrl_ready  = (rd_state == R_IDLE);
   assign dma_read_chnl_valid  = (rd_state == R_BURST);
   assign dma_write_ctrl_ready = (wr_state == W_IDLE);
   assign dma_write_chnl_ready = (wr_state == W_BURST);

   assign rd_ctrl_fire = dma_read_ctrl_valid  & dma_read_ctrl_ready;
   assign rd_beat_fire = dma_read_chnl_valid  & dma_read_chnl_ready;
   assign wr_ctrl_fire = dma_write_ctrl_valid & dma_write_ctrl_ready;
   assign wr_beat_fire = dma_write_chnl_valid & dma_write_chnl_ready;

   // Fetch only when the beat advances, so stalled data holds even if written.
   assign rd_fetch_en   = (rd_ctrl_fire && (dma_read_ctrl_data_length != 32'd0)) || rd_beat_fire;
   assign rd_fetch_addr = (rd_state == R_IDLE) ? dma_read_ctrl_data_index[MEM_ADDR_W-1:0]
                                               : rd_addr + MEM_ADDR_W'(1);

   // DMA write takes priority over a colliding host write.
   assign ram_we    = wr_beat_fire | host_we;
   assign ram_waddr = wr_beat_fire ? wr_addr : host_addr;
   assign ram_wdata = wr_beat_fire ? dma_write_chnl_data : host_wdata;

   dma64_mem_ram #(
      .DATA_W (DMA_BUS_WIDTH),
      .ADDR_W (MEM_ADDR_W)
   ) u_ram (
      .clk     (clk),
      .we      (ram_we),
      .waddr   (ram_waddr),
      .wdata   (ram_wdata),
      .a_en    (rd_fetch_en),
      .a_addr  (rd_fetch_addr),
      .a_rdata (dma_read_chnl_data),
      .b_addr  (host_addr),
      .b_rdata (host_rdata)
   );

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state     <= R_IDLE;
         rd_addr      <= '0;
         rd_remaining <= '0;
      end else begin
         case (rd_state)
            R_IDLE: if (rd_ctrl_fire && (dma_read_ctrl_data_length != 32'd0)) begin
               rd_addr      <= dma_read_ctrl_data_index[MEM_ADDR_W-1:0];
               rd_remaining <= dma_read_ctrl_data_length;
               rd_state     <= R_BURST;
            end
            R_BURST: if (rd_beat_fire) begin
               rd_addr      <= rd_addr + MEM_ADDR_W'(1);
               rd_remaining <= rd_remaining - 32'd1;
               if (rd_remaining == 32'd1) rd_state <= R_IDLE;
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state     <= W_IDLE;
         wr_addr      <= '0;
         wr_remaining <= '0;
      end else begin
         case (wr_state)
            W_IDLE: if (wr_ctrl_fire && (dma_write_ctrl_data_length != 32'd0)) begin
               wr_addr      <= dma_write_ctrl_data_index[MEM_ADDR_W-1:0];
               wr_remaining <= dma_write_ctrl_data_length;
               wr_state     <= W_BURST;
            end
            W_BURST: if (wr_beat_fire) begin
               wr_addr      <= wr_addr + MEM_ADDR_W'(1);
               wr_remaining <= wr_remaining - 32'd1;
               if (wr_remaining == 32'd1) wr_state <= W_IDLE;
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_beat_count <= '0;
         wr_beat_count <= '0;
         size_err      <= 1'b0;
      end else begin
         if (rd_beat_fire) rd_beat_count <= rd_beat_count + 32'd1;
         if (wr_beat_fire) wr_beat_count <= wr_beat_count + 32'd1;
         if ((rd_ctrl_fire && (dma_read_ctrl_data_size  != DMA_SIZE_64)) ||
             (wr_ctrl_fire && (dma_write_ctrl_data_size != DMA_SIZE_64)))
            size_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dma64_mem_responder.sv
// Scoreboard bench for dma64_mem_responder: a bench-side memory model predicts
// read beats, which are queued at request time and popped on each data handshake.
module tb_dma64_mem_responder;

   localparam int W     = 64;
   localparam int AW    = 12;
   localparam int DEPTH = 1 << AW;

   logic          clk, rst;
   logic          dma_read_ctrl_valid, dma_read_ctrl_ready;
   logic [31:0]   dma_read_ctrl_data_index, dma_read_ctrl_data_length;
   logic [2:0]    dma_read_ctrl_data_size;
   logic          dma_read_chnl_valid, dma_read_chnl_ready;
   logic [W-1:0]  dma_read_chnl_data;
   logic          dma_write_ctrl_valid, dma_write_ctrl_ready;
   logic [31:0]   dma_write_ctrl_data_index, dma_write_ctrl_data_length;
   logic [2:0]    dma_write_ctrl_data_size;
   logic          dma_write_chnl_valid, dma_write_chnl_ready;
   logic [W-1:0]  dma_write_chnl_data;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [W-1:0]  host_wdata, host_rdata;
   logic [31:0]   rd_beat_count, wr_beat_count;
   logic          size_err;

   dma64_mem_responder #(.DMA_BUS_WIDTH(W), .MEM_ADDR_W(AW)) dut (
      .clk                        (clk),
      .rst                        (rst),
      .dma_read_ctrl_valid        (dma_read_ctrl_valid),
      .dma_read_ctrl_ready        (dma_read_ctrl_ready),
      .dma_read_ctrl_data_index   (dma_read_ctrl_data_index),
      .dma_read_ctrl_data_length  (dma_read_ctrl_data_length),
      .dma_read_ctrl_data_size    (dma_read_ctrl_data_size),
      .dma_read_chnl_valid        (dma_read_chnl_valid),
      .dma_read_chnl_data         (dma_read_chnl_data),
      .dma_read_chnl_ready        (dma_read_chnl_ready),
      .dma_write_ctrl_valid       (dma_write_ctrl_valid),
      .dma_write_ctrl_ready       (dma_write_ctrl_ready),
      .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
      .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
      .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
      .dma_write_chnl_valid       (dma_write_chnl_valid),
      .dma_write_chnl_data        (dma_write_chnl_data),
      .dma_write_chnl_ready       (dma_write_chnl_ready),
      .host_we                    (host_we),
      .host_addr                  (host_addr),
      .host_wdata                 (host_wdata),
      .host_rdata                 (host_rdata),
      .rd_beat_count              (rd_beat_count),
      .wr_beat_count              (wr_beat_count),
      .size_err                   (size_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int           vectors     = 0;
   int           miscompares = 0;
   logic [W-1:0] model [DEPTH];
   logic [W-1:0] exp_q [$];
   logic [31:0]  exp_rd_cnt, exp_wr_cnt;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input int a, input logic [W-1:0] d);
      host_we    = 1'b1;
      host_addr  = AW'(a);
      host_wdata = d;
      tick();
      host_we    = 1'b0;
      model[a % DEPTH] = d;
   endtask

   task automatic host_read(input int a, output logic [W-1:0] d);
      host_addr = AW'(a);
      tick();
      d = host_rdata;
   endtask

   // Issues one read burst and consumes it with the given per-cycle ready pattern.
   task automatic run_read(input int idx, input int len, input logic [2:0] size,
                           input logic [31:0] rdy_pat, input string name, output int cycles);
      logic [W-1:0] held, exp;
      logic         stalled;
      for (int i = 0; i < len; i++) exp_q.push_back(model[(idx + i) % DEPTH]);
      dma_read_ctrl_data_index  = idx;
      dma_read_ctrl_data_length = len;
      dma_read_ctrl_data_size   = size;
      dma_read_ctrl_valid       = 1'b1;
      #1;
      vectors++;
      if (dma_read_ctrl_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s ctrl_ready: got %b expected 1", name, dma_read_ctrl_ready);
      end
      tick();
      dma_read_ctrl_valid = 1'b0;
      if (len > 0) begin
         vectors++;
         if (dma_read_chnl_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s first_beat_valid: got %b expected 1", name, dma_read_chnl_valid);
         end
      end
      cycles  = 0;
      stalled = 1'b0;
      held    = '0;
      while (exp_q.size() > 0 && cycles < 100) begin
         dma_read_chnl_ready = (cycles < 32) ? rdy_pat[cycles] : 1'b1;
         #1;
         if (stalled) begin
            vectors++;
            if (dma_read_chnl_valid !== 1'b1 || dma_read_chnl_data !== held) begin
               miscompares++;
               $display("FAIL %s stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                        name, dma_read_chnl_valid, dma_read_chnl_data, held);
            end
         end
         stalled = 1'b0;
         if (dma_read_chnl_valid && dma_read_chnl_ready) begin
            exp = exp_q.pop_front();
            exp_rd_cnt++;
            vectors++;
            if (dma_read_chnl_data !== exp) begin
               miscompares++;
               $display("FAIL %s beat: got %h expected %h", name, dma_read_chnl_data, exp);
            end
         end else if (dma_read_chnl_valid) begin
            stalled = 1'b1;
            held    = dma_read_chnl_data;
         end
         cycles++;
         tick();
      end
      dma_read_chnl_ready = 1'b0;
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s timeout: %0d beats outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
      vectors++;
      if (dma_read_chnl_valid !== 1'b0 || dma_read_ctrl_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s burst_end: got valid=%b ctrl_ready=%b expected 0/1",
                  name, dma_read_chnl_valid, dma_read_ctrl_ready);
      end
   endtask

   // Issues one write burst of data base, base+1, ...; gap inserts idle cycles.
   task automatic run_write(input int idx, input int len, input logic [2:0] size,
                            input logic [W-1:0] base, input bit gap, input string name);
      dma_write_ctrl_data_index  = idx;
      dma_write_ctrl_data_length = len;
      dma_write_ctrl_data_size   = size;
      dma_write_ctrl_valid       = 1'b1;
      #1;
      vectors++;
      if (dma_write_ctrl_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s ctrl_ready: got %b expected 1", name, dma_write_ctrl_ready);
      end
      tick();
      dma_write_ctrl_valid = 1'b0;
      for (int i = 0; i < len; i++) begin
         if (gap && i > 0) begin
            dma_write_chnl_valid = 1'b0;
            tick();
         end
         dma_write_chnl_valid = 1'b1;
         dma_write_chnl_data  = base + W'(i);
         #1;
         vectors++;
         if (dma_write_chnl_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s chnl_ready: got %b expected 1", name, dma_write_chnl_ready);
         end
         model[(idx + i) % DEPTH] = base + W'(i);
         exp_wr_cnt++;
         tick();
      end
      dma_write_chnl_valid = 1'b0;
      vectors++;
      if (dma_write_chnl_ready !== 1'b0 || dma_write_ctrl_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s burst_end: got chnl_ready=%b ctrl_ready=%b expected 0/1",
                  name, dma_write_chnl_ready, dma_write_ctrl_ready);
      end
   endtask

   task automatic test_reset();
      logic [8:0] got, exp;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      exp_rd_cnt = 0;
      exp_wr_cnt = 0;
      got = {dma_read_ctrl_ready, dma_write_ctrl_ready, dma_read_chnl_valid,
             dma_write_chnl_ready, size_err, |rd_beat_count, |wr_beat_count, 2'b00};
      exp = 9'b1100_0000_0;
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL reset_state: got %b expected %b", got, exp);
      end
      vectors++;
      if (rd_beat_count !== 32'd0 || wr_beat_count !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_counts: got %0d/%0d expected 0/0", rd_beat_count, wr_beat_count);
      end
   endtask

   task automatic test_basic_read();
      int cyc;
      host_write(0, 64'h11);
      host_write(1, 64'h22);
      host_write(2, 64'h33);
      host_write(3, 64'h44);
      host_write(4, 64'h55);
      run_read(0, 4, 3'b011, 32'hFFFF_FFFF, "basic_read", cyc);
      vectors++;
      if (cyc != 4) begin
         miscompares++;
         $display("FAIL basic_read_cycles: got %0d expected 4", cyc);
      end
      vectors++;
      if (rd_beat_count !== 32'd4) begin
         miscompares++;
         $display("FAIL basic_read_count: got %0d expected 4", rd_beat_count);
      end
   endtask

   task automatic test_stall_read();
      int cyc;
      run_read(2, 3, 3'b011, 32'b1_1001, "stall_read", cyc);
      vectors++;
      if (cyc != 5 || rd_beat_count !== exp_rd_cnt) begin
         miscompares++;
         $display("FAIL stall_read_cycles: got %0d cycles count %0d expected 5 cycles count %0d",
                  cyc, rd_beat_count, exp_rd_cnt);
      end
   endtask

   task automatic test_write_wrap();
      logic [W-1:0] d;
      int           cyc;
      int           addrs [4] = '{4094, 4095, 0, 1};
      run_write(4094, 4, 3'b011, 64'hA, 1'b0, "write_wrap");
      for (int i = 0; i < 4; i++) begin
         host_read(addrs[i], d);
         vectors++;
         if (d !== 64'hA + W'(i)) begin
            miscompares++;
            $display("FAIL write_wrap_mem[%0d]: got %h expected %h", addrs[i], d, 64'hA + W'(i));
         end
      end
      run_read(4094, 4, 3'b011, 32'hFFFF_FFFF, "read_wrap", cyc);
      vectors++;
      if (wr_beat_count !== exp_wr_cnt) begin
         miscompares++;
         $display("FAIL write_wrap_count: got %0d expected %0d", wr_beat_count, exp_wr_cnt);
      end
   endtask

   task automatic test_zero_length();
      dma_read_ctrl_data_index   = 7;
      dma_read_ctrl_data_length  = 0;
      dma_read_ctrl_data_size    = 3'b011;
      dma_write_ctrl_data_index  = 9;
      dma_write_ctrl_data_length = 0;
      dma_write_ctrl_data_size   = 3'b011;
      dma_read_ctrl_valid  = 1'b1;
      dma_write_ctrl_valid = 1'b1;
      tick();
      dma_read_ctrl_valid  = 1'b0;
      dma_write_ctrl_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         vectors++;
         if (dma_read_ctrl_ready !== 1'b1 || dma_write_ctrl_ready !== 1'b1 ||
             dma_read_chnl_valid !== 1'b0 || dma_write_chnl_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len_idle: got rcr=%b wcr=%b rv=%b wr=%b expected 1/1/0/0",
                     dma_read_ctrl_ready, dma_write_ctrl_ready,
                     dma_read_chnl_valid, dma_write_chnl_ready);
         end
         tick();
      end
      vectors++;
      if (rd_beat_count !== exp_rd_cnt || wr_beat_count !== exp_wr_cnt || size_err !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_len_counts: got %0d/%0d err=%b expected %0d/%0d err=0",
                  rd_beat_count, wr_beat_count, size_err, exp_rd_cnt, exp_wr_cnt);
      end
   endtask

   task automatic test_concurrent();
      logic [W-1:0] d;
      host_write(200, 64'h1234);
      dma_read_ctrl_data_index   = 200;
      dma_read_ctrl_data_length  = 1;
      dma_read_ctrl_data_size    = 3'b011;
      dma_write_ctrl_data_index  = 200;
      dma_write_ctrl_data_length = 1;
      dma_write_ctrl_data_size   = 3'b011;
      dma_read_ctrl_valid  = 1'b1;
      dma_write_ctrl_valid = 1'b1;
      tick();
      dma_read_ctrl_valid  = 1'b0;
      dma_write_ctrl_valid = 1'b0;
      exp_q.push_back(model[200]);
      dma_read_chnl_ready  = 1'b1;
      dma_write_chnl_valid = 1'b1;
      dma_write_chnl_data  = 64'h5678;
      #1;
      vectors++;
      if (dma_read_chnl_valid !== 1'b1 || dma_write_chnl_ready !== 1'b1 ||
          dma_read_chnl_data !== exp_q[0]) begin
         miscompares++;
         $display("FAIL concurrent_beat: got rv=%b wr=%b data=%h expected 1/1 data=%h",
                  dma_read_chnl_valid, dma_write_chnl_ready, dma_read_chnl_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      exp_rd_cnt++;
      exp_wr_cnt++;
      model[200] = 64'h5678;
      tick();
      dma_read_chnl_ready  = 1'b0;
      dma_write_chnl_valid = 1'b0;
      host_read(200, d);
      vectors++;
      if (d !== model[200]) begin
         miscompares++;
         $display("FAIL concurrent_mem: got %h expected %h", d, model[200]);
      end
      vectors++;
      if (rd_beat_count !== exp_rd_cnt || wr_beat_count !== exp_wr_cnt) begin
         miscompares++;
         $display("FAIL concurrent_counts: got %0d/%0d expected %0d/%0d",
                  rd_beat_count, wr_beat_count, exp_rd_cnt, exp_wr_cnt);
      end
   endtask

   task automatic test_host_collision();
      logic [W-1:0] d;
      dma_write_ctrl_data_index  = 300;
      dma_write_ctrl_data_length = 1;
      dma_write_ctrl_data_size   = 3'b011;
      dma_write_ctrl_valid       = 1'b1;
      tick();
      dma_write_ctrl_valid = 1'b0;
      dma_write_chnl_valid = 1'b1;
      dma_write_chnl_data  = 64'hD0D0;
      host_we    = 1'b1;
      host_addr  = AW'(300);
      host_wdata = 64'h0BAD;
      tick();
      host_we = 1'b0;
      dma_write_chnl_valid = 1'b0;
      model[300] = 64'hD0D0;
      exp_wr_cnt++;
      host_read(300, d);
      vectors++;
      if (d !== model[300]) begin
         miscompares++;
         $display("FAIL host_collision: got %h expected %h", d, model[300]);
      end
   endtask

   task automatic test_size_err();
      int cyc;
      run_read(0, 1, 3'b010, 32'hFFFF_FFFF, "size_err_read", cyc);
      vectors++;
      if (size_err !== 1'b1) begin
         miscompares++;
         $display("FAIL size_err_set: got %b expected 1", size_err);
      end
      run_write(10, 1, 3'b011, 64'h77, 1'b0, "size_ok_write");
      run_read(10, 1, 3'b011, 32'hFFFF_FFFF, "size_ok_read", cyc);
      vectors++;
      if (size_err !== 1'b1) begin
         miscompares++;
         $display("FAIL size_err_sticky: got %b expected 1", size_err);
      end
   endtask

   task automatic test_back_to_back();
      int           idx, len, cyc;
      logic [W-1:0] base;
      for (int t = 0; t < 3; t++) begin
         idx  = $urandom_range(DEPTH - 1, 0);
         len  = $urandom_range(6, 1);
         base = {$urandom, $urandom};
         run_write(idx, len, 3'b011, base, 1'(t % 2), "b2b_write");
         run_read(idx, len, 3'b011, $urandom | 32'h1, "b2b_read", cyc);
      end
      vectors++;
      if (rd_beat_count !== exp_rd_cnt || wr_beat_count !== exp_wr_cnt) begin
         miscompares++;
         $display("FAIL b2b_counts: got %0d/%0d expected %0d/%0d",
                  rd_beat_count, wr_beat_count, exp_rd_cnt, exp_wr_cnt);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [W-1:0] d;
      dma_read_ctrl_data_index  = 0;
      dma_read_ctrl_data_length = 8;
      dma_read_ctrl_data_size   = 3'b011;
      dma_read_ctrl_valid       = 1'b1;
      tick();
      dma_read_ctrl_valid = 1'b0;
      dma_read_chnl_ready = 1'b1;
      for (int b = 0; b < 2; b++) begin
         vectors++;
         if (dma_read_chnl_valid !== 1'b1 || dma_read_chnl_data !== model[b]) begin
            miscompares++;
            $display("FAIL mid_burst_beat%0d: got valid=%b data=%h expected 1 %h",
                     b, dma_read_chnl_valid, dma_read_chnl_data, model[b]);
         end
         tick();
      end
      dma_read_chnl_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_rd_cnt = 0;
      exp_wr_cnt = 0;
      vectors++;
      if (dma_read_chnl_valid !== 1'b0 || dma_read_ctrl_ready !== 1'b1 ||
          rd_beat_count !== 32'd0 || size_err !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_burst_reset: got valid=%b ready=%b count=%0d err=%b expected 0/1/0/0",
                  dma_read_chnl_valid, dma_read_ctrl_ready, rd_beat_count, size_err);
      end
      dma_read_chnl_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         vectors++;
         if (dma_read_chnl_valid !== 1'b0 || rd_beat_count !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_burst_no_beats: got valid=%b count=%0d expected 0/0",
                     dma_read_chnl_valid, rd_beat_count);
         end
      end
      dma_read_chnl_ready = 1'b0;
      for (int a = 0; a < 4; a++) begin
         host_read(a, d);
         vectors++;
         if (d !== model[a]) begin
            miscompares++;
            $display("FAIL mem_preserved[%0d]: got %h expected %h", a, d, model[a]);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      dma_read_ctrl_valid = 1'b0;  dma_read_ctrl_data_index = '0;
      dma_read_ctrl_data_length = '0;  dma_read_ctrl_data_size = 3'b011;
      dma_read_chnl_ready = 1'b0;
      dma_write_ctrl_valid = 1'b0; dma_write_ctrl_data_index = '0;
      dma_write_ctrl_data_length = '0; dma_write_ctrl_data_size = 3'b011;
      dma_write_chnl_valid = 1'b0; dma_write_chnl_data = '0;
      host_we = 1'b0; host_addr = '0; host_wdata = '0;
      exp_rd_cnt = 0; exp_wr_cnt = 0;

      test_reset();
      test_basic_read();
      test_stall_read();
      test_write_wrap();
      test_zero_length();
      test_concurrent();
      test_host_collision();
      test_back_to_back();
      test_size_err();
      test_reset_mid_burst();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
